// File: rtl/uart_rx_cmd_ctrl.sv
// Command-frame controller between the UART receiver, register file, ALU and UART transmitter.
// Optional inter-byte/response timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_d_vld,
    input  logic [DATA_WIDTH-1:0]   rx_p_data,
    input  logic                    rx_err,
    output logic                    rf_wr_en,
    output logic                    rf_rd_en,
    output logic [ADDR_WIDTH-1:0]   rf_addr,
    output logic [DATA_WIDTH-1:0]   rf_wr_data,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    input  logic                    rf_rd_vld,
    output logic                    alu_en,
    output logic [3:0]              alu_fun,
    output logic                    clk_gate_en,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_vld,
    output logic                    tx_d_vld,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    input  logic                    tx_rdy,
    output logic                    frame_err
);

    localparam logic [DATA_WIDTH-1:0] OPC_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPC_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU    = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN,
        RD_WAIT, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [DATA_WIDTH-1:0]   res_hi, res_hi_n;
    logic                    two_byte, two_byte_n;
    logic                    alu_pend, alu_pend_n;
    logic                    abort;

    logic                    rf_wr_en_n, rf_rd_en_n, alu_en_n, clk_gate_en_n;
    logic                    tx_d_vld_n, frame_err_n;
    logic [ADDR_WIDTH-1:0]   rf_addr_n;
    logic [DATA_WIDTH-1:0]   rf_wr_data_n, tx_p_data_n;
    logic [3:0]              alu_fun_n;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             cnt_run;

    assign cnt_run = (state != IDLE) && (state != TX_LO) && (state != TX_HI);

    // Counter restarts on any state change; accepted bytes always change state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!cnt_run || (state_n != state)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    assign abort = rx_d_vld && rx_err;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            res_hi      <= '0;
            two_byte    <= 1'b0;
            alu_pend    <= 1'b0;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= '0;
            clk_gate_en <= 1'b0;
            tx_d_vld    <= 1'b0;
            tx_p_data   <= '0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            res_hi      <= res_hi_n;
            two_byte    <= two_byte_n;
            alu_pend    <= alu_pend_n;
            rf_wr_en    <= rf_wr_en_n;
            rf_rd_en    <= rf_rd_en_n;
            rf_addr     <= rf_addr_n;
            rf_wr_data  <= rf_wr_data_n;
            alu_en      <= alu_en_n;
            alu_fun     <= alu_fun_n;
            clk_gate_en <= clk_gate_en_n;
            tx_d_vld    <= tx_d_vld_n;
            tx_p_data   <= tx_p_data_n;
            frame_err   <= frame_err_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n       = state;
        addr_n        = addr_q;
        res_hi_n      = res_hi;
        two_byte_n    = two_byte;
        alu_pend_n    = alu_pend;
        rf_wr_en_n    = 1'b0;
        rf_rd_en_n    = 1'b0;
        rf_addr_n     = rf_addr;
        rf_wr_data_n  = rf_wr_data;
        alu_en_n      = 1'b0;
        alu_fun_n     = alu_fun;
        clk_gate_en_n = clk_gate_en;
        tx_d_vld_n    = tx_d_vld;
        tx_p_data_n   = tx_p_data;
        frame_err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_d_vld && !rx_err) begin
                    case (rx_p_data)
                        OPC_WR:     state_n = WR_ADDR;
                        OPC_RD:     state_n = RD_ADDR;
                        OPC_ALU_OP: state_n = OP_A;
                        OPC_ALU:    state_n = ALU_FUN;
                        default:    state_n = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    addr_n  = rx_p_data[ADDR_WIDTH-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = addr_q;
                    rf_wr_data_n = rx_p_data;
                    state_n      = IDLE;
                end
            end
            RD_ADDR: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    rf_rd_en_n = 1'b1;
                    rf_addr_n  = rx_p_data[ADDR_WIDTH-1:0];
                    state_n    = RD_WAIT;
                end
            end
            OP_A: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = '0;
                    rf_wr_data_n = rx_p_data;
                    state_n      = OP_B;
                end
            end
            OP_B: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = ADDR_WIDTH'(1);
                    rf_wr_data_n = rx_p_data;
                    state_n      = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (abort) begin
                    state_n     = IDLE;
                    frame_err_n = 1'b1;
                end else if (rx_d_vld) begin
                    clk_gate_en_n = 1'b1;
                    alu_fun_n     = rx_p_data[3:0];
                    alu_pend_n    = 1'b1;
                    state_n       = ALU_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_vld) begin
                    tx_d_vld_n  = 1'b1;
                    tx_p_data_n = rf_rd_data;
                    two_byte_n  = 1'b0;
                    state_n     = TX_LO;
                end
            end
            ALU_WAIT: begin
                // ALU_EN lags the gate enable by one cycle so the gated clock is running.
                if (alu_pend) begin
                    alu_en_n   = 1'b1;
                    alu_pend_n = 1'b0;
                end else if (alu_out_vld) begin
                    clk_gate_en_n = 1'b0;
                    tx_d_vld_n    = 1'b1;
                    tx_p_data_n   = alu_out[DATA_WIDTH-1:0];
                    res_hi_n      = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                    two_byte_n    = 1'b1;
                    state_n       = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_rdy) begin
                    if (two_byte) begin
                        tx_p_data_n = res_hi;
                        state_n     = TX_HI;
                    end else begin
                        tx_d_vld_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            TX_HI: begin
                if (tx_rdy) begin
                    tx_d_vld_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        if (cnt_run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && (state_n == state)) begin
            state_n       = IDLE;
            frame_err_n   = 1'b1;
            clk_gate_en_n = 1'b0;
            alu_pend_n    = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard testbench for uart_rx_cmd_ctrl; TX bytes are queued when stimulus is driven.
`timescale 1ns/1ps
module tb_uart_rx_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_d_vld, rx_err, rf_rd_vld, alu_out_vld, tx_rdy;
    logic [7:0]  rx_p_data, rf_rd_data;
    logic [15:0] alu_out;
    logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_vld, frame_err;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, tx_p_data;

    int tests = 0;
    int fails = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .rx_d_vld(rx_d_vld), .rx_p_data(rx_p_data), .rx_err(rx_err),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_vld(rf_rd_vld),
        .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
        .alu_out(alu_out), .alu_out_vld(alu_out_vld),
        .tx_d_vld(tx_d_vld), .tx_p_data(tx_p_data), .tx_rdy(tx_rdy),
        .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (rf_wr_en) wr_pulses <= wr_pulses + 1;
        if (rf_rd_en) rd_pulses <= rd_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_d_vld  = 1'b1;
        rx_p_data = b;
        rx_err    = err;
        cyc();
        rx_d_vld  = 1'b0;
        rx_err    = 1'b0;
        rx_p_data = 8'h00;
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        repeat (3) cyc();
        outs = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                clk_gate_en, tx_d_vld, tx_p_data, frame_err};
        tests++;
        if (outs !== 30'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int wr0;
        wr0 = wr_pulses;
        send(8'hAA, 1'b0);
        send(8'h05, 1'b0);
        tests++;
        if (rf_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL write_early: rf_wr_en=%b after addr byte, required 0", rf_wr_en);
        end
        send(8'h3C, 1'b0);
        tests++;
        if (rf_wr_en !== 1'b1 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
            fails++;
            $display("FAIL write_strobe: en=%b addr=%h data=%h, required 1/5/3c",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        cyc();
        tests++;
        if (rf_wr_en !== 1'b0 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
            fails++;
            $display("FAIL write_hold: en=%b addr=%h data=%h, required 0/5/3c",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        cyc();
        tests++;
        if (wr_pulses - wr0 !== 1) begin
            fails++;
            $display("FAIL write_count: %0d pulses, required 1", wr_pulses - wr0);
        end
    endtask

    task automatic test_read();
        logic [7:0] e;
        send(8'hBB, 1'b0);
        send(8'h02, 1'b0);
        tests++;
        if (rf_rd_en !== 1'b1 || rf_addr !== 4'h2) begin
            fails++;
            $display("FAIL read_strobe: en=%b addr=%h, required 1/2", rf_rd_en, rf_addr);
        end
        cyc();
        tests++;
        if (rf_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL read_pulse_width: en=%b, required 0", rf_rd_en);
        end
        rf_rd_vld  = 1'b1;
        rf_rd_data = 8'h7E;
        exp_q.push_back(8'h7E);
        cyc();
        rf_rd_vld  = 1'b0;
        rf_rd_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (tx_d_vld !== 1'b1 || tx_p_data !== 8'h7E) begin
                fails++;
                $display("FAIL read_tx_hold[%0d]: vld=%b data=%h, required 1/7e", i, tx_d_vld, tx_p_data);
            end
            cyc();
        end
        tx_rdy = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (tx_d_vld !== 1'b1 || tx_p_data !== e) begin
            fails++;
            $display("FAIL read_tx_byte: vld=%b data=%h, required 1/%h", tx_d_vld, tx_p_data, e);
        end
        cyc();
        tx_rdy = 1'b0;
        tests++;
        if (tx_d_vld !== 1'b0) begin
            fails++;
            $display("FAIL read_tx_done: vld=%b, required 0", tx_d_vld);
        end
    endtask

    task automatic test_alu_frame();
        logic [7:0] e;
        send(8'hCC, 1'b0);
        send(8'h10, 1'b0);
        tests++;
        if (rf_wr_en !== 1'b1 || rf_addr !== 4'h0 || rf_wr_data !== 8'h10) begin
            fails++;
            $display("FAIL alu_op_a: en=%b addr=%h data=%h, required 1/0/10", rf_wr_en, rf_addr, rf_wr_data);
        end
        send(8'h20, 1'b0);
        tests++;
        if (rf_wr_en !== 1'b1 || rf_addr !== 4'h1 || rf_wr_data !== 8'h20) begin
            fails++;
            $display("FAIL alu_op_b: en=%b addr=%h data=%h, required 1/1/20", rf_wr_en, rf_addr, rf_wr_data);
        end
        send(8'h01, 1'b0);
        tests++;
        if (clk_gate_en !== 1'b1 || alu_en !== 1'b0 || rf_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL alu_gate_first: gate=%b alu_en=%b wr=%b, required 1/0/0", clk_gate_en, alu_en, rf_wr_en);
        end
        cyc();
        tests++;
        if (alu_en !== 1'b1 || alu_fun !== 4'h1 || clk_gate_en !== 1'b1) begin
            fails++;
            $display("FAIL alu_start: alu_en=%b fun=%h gate=%b, required 1/1/1", alu_en, alu_fun, clk_gate_en);
        end
        send(8'h55, 1'b1);
        tests++;
        if (alu_en !== 1'b0 || frame_err !== 1'b0 || clk_gate_en !== 1'b1) begin
            fails++;
            $display("FAIL alu_wait_drop: alu_en=%b ferr=%b gate=%b, required 0/0/1", alu_en, frame_err, clk_gate_en);
        end
        tx_rdy      = 1'b1;
        alu_out     = 16'h0030;
        alu_out_vld = 1'b1;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h00);
        cyc();
        alu_out_vld = 1'b0;
        alu_out     = 16'hFFFF;
        tests++;
        if (clk_gate_en !== 1'b0) begin
            fails++;
            $display("FAIL alu_gate_drop: gate=%b, required 0", clk_gate_en);
        end
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            tests++;
            if (tx_d_vld !== 1'b1 || tx_p_data !== e) begin
                fails++;
                $display("FAIL alu_tx_byte[%0d]: vld=%b data=%h, required 1/%h", i, tx_d_vld, tx_p_data, e);
            end
            cyc();
        end
        tx_rdy = 1'b0;
        tests++;
        if (tx_d_vld !== 1'b0) begin
            fails++;
            $display("FAIL alu_tx_done: vld=%b, required 0", tx_d_vld);
        end
    endtask

    task automatic test_frame_err();
        int wr0;
        int budget;
        logic [7:0] e;
        wr0 = wr_pulses;
        send(8'h12, 1'b0);
        send(8'hAA, 1'b1);
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignore: ferr=%b, required 0", frame_err);
        end
        send(8'hAA, 1'b0);
        send(8'h05, 1'b0);
        send(8'h77, 1'b1);
        tests++;
        if (frame_err !== 1'b1 || rf_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_pulse: ferr=%b wr=%b, required 1/0", frame_err, rf_wr_en);
        end
        cyc();
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL abort_width: ferr=%b, required 0", frame_err);
        end
        cyc();
        tests++;
        if (wr_pulses !== wr0) begin
            fails++;
            $display("FAIL abort_no_write: %0d pulses, required 0", wr_pulses - wr0);
        end
        send(8'hDD, 1'b0);
        send(8'h02, 1'b0);
        cyc();
        tests++;
        if (alu_en !== 1'b1 || alu_fun !== 4'h2) begin
            fails++;
            $display("FAIL dd_start: alu_en=%b fun=%h, required 1/2", alu_en, alu_fun);
        end
        alu_out     = 16'hBEEF;
        alu_out_vld = 1'b1;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        cyc();
        alu_out_vld = 1'b0;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            tx_rdy = 1'($urandom_range(0, 1));
            if (tx_d_vld && tx_rdy) begin
                e = exp_q.pop_front();
                tests++;
                if (tx_p_data !== e) begin
                    fails++;
                    $display("FAIL dd_tx_byte: data=%h, required %h", tx_p_data, e);
                end
            end
            cyc();
            budget--;
        end
        tx_rdy = 1'b0;
        tests++;
        if (exp_q.size() != 0 || tx_d_vld !== 1'b0) begin
            fails++;
            $display("FAIL dd_tx_drain: %0d bytes left vld=%b, required 0/0", exp_q.size(), tx_d_vld);
        end
    endtask

    task automatic test_timeout();
        int rd0;
        rd0 = rd_pulses;
`ifdef UART_CMD_TIMEOUT_EN
        send(8'hBB, 1'b0);
        for (int i = 1; i < 16; i++) begin
            cyc();
            tests++;
            if (frame_err !== 1'b0) begin
                fails++;
                $display("FAIL timeout_early[%0d]: ferr=%b, required 0", i, frame_err);
            end
        end
        cyc();
        tests++;
        if (frame_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_abort: ferr=%b, required 1", frame_err);
        end
        cyc();
        tests++;
        if (rd_pulses !== rd0) begin
            fails++;
            $display("FAIL timeout_no_read: %0d pulses, required 0", rd_pulses - rd0);
        end
        send(8'hBB, 1'b0);
        repeat (15) cyc();
        send(8'h03, 1'b0);
        tests++;
        if (rf_rd_en !== 1'b1 || frame_err !== 1'b0 || rf_addr !== 4'h3) begin
            fails++;
            $display("FAIL timeout_byte_wins: rd=%b ferr=%b addr=%h, required 1/0/3", rf_rd_en, frame_err, rf_addr);
        end
        repeat (16) cyc();
        tests++;
        if (frame_err !== 1'b1 || tx_d_vld !== 1'b0) begin
            fails++;
            $display("FAIL timeout_rd_wait: ferr=%b vld=%b, required 1/0", frame_err, tx_d_vld);
        end
        cyc();
`else
        send(8'hBB, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc();
            tests++;
            if (frame_err !== 1'b0) begin
                fails++;
                $display("FAIL no_timeout[%0d]: ferr=%b, required 0", i, frame_err);
            end
        end
        send(8'h03, 1'b0);
        tests++;
        if (rf_rd_en !== 1'b1 || rf_addr !== 4'h3) begin
            fails++;
            $display("FAIL no_timeout_read: rd=%b addr=%h, required 1/3", rf_rd_en, rf_addr);
        end
        repeat (30) cyc();
        rf_rd_vld  = 1'b1;
        rf_rd_data = 8'h11;
        tx_rdy     = 1'b1;
        cyc();
        rf_rd_vld  = 1'b0;
        tests++;
        if (tx_d_vld !== 1'b1 || tx_p_data !== 8'h11) begin
            fails++;
            $display("FAIL no_timeout_tx: vld=%b data=%h, required 1/11", tx_d_vld, tx_p_data);
        end
        cyc();
        tx_rdy = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        logic [29:0] outs;
        send(8'hDD, 1'b0);
        send(8'h03, 1'b0);
        cyc();
        tests++;
        if (clk_gate_en !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_gate: gate=%b, required 1", clk_gate_en);
        end
        #2;
        rst = 1'b1;
        #1;
        outs = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                clk_gate_en, tx_d_vld, tx_p_data, frame_err};
        tests++;
        if (outs !== 30'h0) begin
            fails++;
            $display("FAIL rst_async: outputs %h, required 0", outs);
        end
        cyc();
        rst = 1'b0;
        cyc();
        send(8'hAA, 1'b0);
        send(8'h09, 1'b0);
        send(8'h5A, 1'b0);
        tests++;
        if (rf_wr_en !== 1'b1 || rf_addr !== 4'h9 || rf_wr_data !== 8'h5A || clk_gate_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_recover: wr=%b addr=%h data=%h gate=%b, required 1/9/5a/0",
                     rf_wr_en, rf_addr, rf_wr_data, clk_gate_en);
        end
        cyc();
    endtask

    initial begin
        rst         = 1'b1;
        rx_d_vld    = 1'b0;
        rx_p_data   = 8'h00;
        rx_err      = 1'b0;
        rf_rd_data  = 8'h00;
        rf_rd_vld   = 1'b0;
        alu_out     = 16'h0000;
        alu_out_vld = 1'b0;
        tx_rdy      = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_alu_frame();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
